// File: rtl/alu_exec_if.sv
// Handshake and operand/result bundle between ALU control and the execute-stage ALU.
// The requester drives the request fields; the ALU drives status and result.
interface alu_exec_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;

  modport master (
    output start, alu_ctrl, a, b,
    input  busy, done, result, zero, ovf
  );

  modport slave (
    input  start, alu_ctrl, a, b,
    output busy, done, result, zero, ovf
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus iterative one-bit-per-cycle
// logical shifts under a start/busy/done handshake. Result and flags are registered.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_SLL = 3'd3;
  localparam logic [2:0] OP_SRL = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  logic [0:0]       state, state_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             zero_q, zero_nxt;
  logic             ovf_q, ovf_nxt;
  logic             left_q, left_nxt;
  logic [WIDTH-1:0] result_q, result_nxt;
  logic [WIDTH-1:0] work_q, work_nxt;
  logic [SHW-1:0]   cnt_q, cnt_nxt;

  logic [WIDTH-1:0] sum_c, diff_c, alu_res_c, work_step_c;
  logic [SHW-1:0]   shamt_c;
  logic             alu_ovf_c, is_shift_c;

  // Single-cycle datapath on the live operands
  always_comb begin
    sum_c      = bus.a + bus.b;
    diff_c     = bus.a - bus.b;
    shamt_c    = bus.b[SHW-1:0];
    is_shift_c = (bus.alu_ctrl == OP_SLL) || (bus.alu_ctrl == OP_SRL);
    alu_res_c  = '0;
    alu_ovf_c  = 1'b0;
    case (bus.alu_ctrl)
      OP_ADD: begin
        alu_res_c = sum_c;
        alu_ovf_c = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_c[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_c = diff_c;
        alu_ovf_c = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_c[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_NOT:  alu_res_c = ~bus.a;
      OP_SLL:  alu_res_c = bus.a;  // only reached with a zero shift amount
      OP_SRL:  alu_res_c = bus.a;
      OP_AND:  alu_res_c = bus.a & bus.b;
      OP_OR:   alu_res_c = bus.a | bus.b;
      OP_SLT:  alu_res_c = WIDTH'(($signed(bus.a) < $signed(bus.b)) ? 1'b1 : 1'b0);
      default: alu_res_c = '0;
    endcase
  end

  assign work_step_c = left_q ? (work_q << 1) : (work_q >> 1);

  // Next-state and registered-output logic
  always_comb begin
    state_nxt  = state;
    busy_nxt   = busy_q;
    done_nxt   = 1'b0;
    zero_nxt   = zero_q;
    ovf_nxt    = ovf_q;
    left_nxt   = left_q;
    result_nxt = result_q;
    work_nxt   = work_q;
    cnt_nxt    = cnt_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (is_shift_c && (shamt_c != '0)) begin
            work_nxt  = bus.a;
            cnt_nxt   = shamt_c;
            left_nxt  = (bus.alu_ctrl == OP_SLL);
            busy_nxt  = 1'b1;
            state_nxt = SHIFT;
          end else begin
            result_nxt = alu_res_c;
            zero_nxt   = (alu_res_c == '0);
            ovf_nxt    = alu_ovf_c;
            done_nxt   = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_nxt = work_step_c;
        cnt_nxt  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_nxt = work_step_c;
          zero_nxt   = (work_step_c == '0);
          ovf_nxt    = 1'b0;
          done_nxt   = 1'b1;
          busy_nxt   = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      left_q   <= 1'b0;
      result_q <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state    <= state_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      zero_q   <= zero_nxt;
      ovf_q    <= ovf_nxt;
      left_q   <= left_nxt;
      result_q <= result_nxt;
      work_q   <= work_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against a cycle-count reference model.
module tb_alu_exec_unit;
  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(WIDTH)) bus ();
  alu_exec_unit #(.WIDTH(WIDTH), .SHW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: what the outputs must be after each edge
  int          m_remain = 0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_res = '0;
  logic        m_zero = 1'b1;
  logic        m_ovf = 1'b0;
  logic        m_done = 1'b0;
  logic        m_busy = 1'b0;

  function automatic int r_n(input logic [2:0] op, input logic [15:0] b);
    if (op == 3'd3 || op == 3'd4) return int'(b) % 16;
    return 0;
  endfunction

  function automatic logic [15:0] r_res(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb;
    int n;
    sa = int'($signed(a));
    sb = int'($signed(b));
    n  = int'(b) % 16;
    case (op)
      3'd0: return 16'(sa + sb);
      3'd1: return 16'(sa - sb);
      3'd2: return ~a;
      3'd3: return 16'(int'(a) * (1 << n));
      3'd4: return 16'(int'(a) / (1 << n));
      3'd5: return a & b;
      3'd6: return a | b;
      default: return (sa < sb) ? 16'd1 : 16'd0;
    endcase
  endfunction

  function automatic logic r_ovf(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int s;
    if (op == 3'd0) s = int'($signed(a)) + int'($signed(b));
    else if (op == 3'd1) s = int'($signed(a)) - int'($signed(b));
    else return 1'b0;
    return (s > 32767) || (s < -32768);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_remain <= 0;
      m_res    <= '0;
      m_zero   <= 1'b1;
      m_ovf    <= 1'b0;
      m_done   <= 1'b0;
      m_busy   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_remain > 0) begin
        m_remain <= m_remain - 1;
        if (m_remain == 1) begin
          m_res  <= m_pend;
          m_zero <= (m_pend == 16'd0);
          m_ovf  <= 1'b0;
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end else if (bus.start) begin
        if (r_n(bus.alu_ctrl, bus.b) > 0) begin
          m_remain <= r_n(bus.alu_ctrl, bus.b);
          m_pend   <= r_res(bus.alu_ctrl, bus.a, bus.b);
          m_busy   <= 1'b1;
        end else begin
          m_res  <= r_res(bus.alu_ctrl, bus.a, bus.b);
          m_zero <= (r_res(bus.alu_ctrl, bus.a, bus.b) == 16'd0);
          m_ovf  <= r_ovf(bus.alu_ctrl, bus.a, bus.b);
          m_done <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("mdl_done",   16'(bus.done), 16'(m_done));
    chk("mdl_busy",   16'(bus.busy), 16'(m_busy));
    chk("mdl_result", bus.result,    m_res);
    chk("mdl_zero",   16'(bus.zero), 16'(m_zero));
    chk("mdl_ovf",    16'(bus.ovf),  16'(m_ovf));
  end

  task automatic check_reset_vals(input string nm);
    chk({nm, "_result"}, bus.result, 16'h0000);
    chk({nm, "_zero"},   16'(bus.zero), 16'd1);
    chk({nm, "_ovf"},    16'(bus.ovf),  16'd0);
    chk({nm, "_busy"},   16'(bus.busy), 16'd0);
    chk({nm, "_done"},   16'(bus.done), 16'd0);
  endtask

  // One request, then wait for done and pin result/flags/latency to literals
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic eo, input int elat, input string nm);
    int k;
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctrl = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!bus.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) begin
      chk({nm, "_timeout"}, 16'd0, 16'd1);
    end else begin
      chk({nm, "_result"}, bus.result, er);
      chk({nm, "_ovf"},    16'(bus.ovf), 16'(eo));
      chk({nm, "_zero"},   16'(bus.zero), 16'(er == 16'd0));
      chk({nm, "_lat"},    16'(k), 16'(elat));
    end
  endtask

  logic [2:0]  bo [5];
  logic [15:0] ba [5];
  logic [15:0] bb [5];
  logic [15:0] be [5];

  initial begin
    int k;
    bus.start = 1'b0; bus.alu_ctrl = 3'd0; bus.a = '0; bus.b = '0;
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bus.start = 1'b1; bus.alu_ctrl = 3'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
      check_reset_vals("rst");
    end
    @(negedge clk);
    bus.start = 1'b0;
    #2 rst_n = 1'b1;

    do_op(3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 0, "add_ovf");
    do_op(3'd1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 0, "sub_zero");
    do_op(3'd3, 16'h0001, 16'd15,   16'h8000, 1'b0, 15, "sll15");
    do_op(3'd4, 16'h8000, 16'd4,    16'h0800, 1'b0, 4, "srl4");
    do_op(3'd3, 16'h1234, 16'h0010, 16'h1234, 1'b0, 0, "sll0");
    do_op(3'd4, 16'hFFFF, 16'h0013, 16'h1FFF, 1'b0, 3, "srl_mask");

    // Back-to-back single-cycle ops
    bo[0] = 3'd2; ba[0] = 16'h00FF; bb[0] = 16'h0000; be[0] = 16'hFF00;
    bo[1] = 3'd5; ba[1] = 16'hF0F0; bb[1] = 16'h0FF0; be[1] = 16'h00F0;
    bo[2] = 3'd6; ba[2] = 16'hF0F0; bb[2] = 16'h0FF0; be[2] = 16'hFFF0;
    bo[3] = 3'd7; ba[3] = 16'h8000; bb[3] = 16'h0001; be[3] = 16'h0001;
    bo[4] = 3'd7; ba[4] = 16'h0001; bb[4] = 16'h8000; be[4] = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_done", 16'(bus.done), 16'd1);
        chk("b2b_result", bus.result, be[i-1]);
      end
      bus.start = 1'b1; bus.alu_ctrl = bo[i]; bus.a = ba[i]; bus.b = bb[i];
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_done", 16'(bus.done), 16'd1);
    chk("b2b_result", bus.result, be[4]);

    // Busy interlock: ADD requests during a shift are ignored until the done cycle
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctrl = 3'd4; bus.a = 16'hABCD; bus.b = 16'd8;
    k = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b1; bus.alu_ctrl = 3'd0; bus.a = 16'd1; bus.b = 16'd2;
      if (!bus.done) k++;
    end while (!bus.done && k < 40);
    chk("lock_lat", 16'(k), 16'd8);
    chk("lock_result", bus.result, 16'h00AB);
    @(negedge clk);
    bus.start = 1'b0;
    chk("lock_next_done", 16'(bus.done), 16'd1);
    chk("lock_next_result", bus.result, 16'h0003);

    // Reset in the middle of a shift
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctrl = 3'd3; bus.a = 16'h0003; bus.b = 16'd10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      chk("midrst_no_done", 16'(bus.done), 16'd0);
    end

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      bus.start    = ($urandom_range(0, 9) < 7);
      bus.alu_ctrl = 3'($urandom);
      case ($urandom_range(0, 3))
        0: bus.a = 16'h7FFF;
        1: bus.a = 16'h8000;
        default: bus.a = 16'($urandom);
      endcase
      bus.b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

16-bit execute-stage ALU that consumes the 3-bit `alu_ctrl` code produced by ALU control and the two register operands, and returns a registered result plus flags. Logic/arithmetic ops complete in one cycle; logical shifts run iteratively, one bit per cycle, under a start/busy/done handshake. The block sits directly downstream of ALU control and feeds the writeback mux and the branch-compare logic (`zero`).

## Interface

Parameters:
- `WIDTH`, 16, operand/result width.
- `SHW`, 4, shift-amount width; shift amount is `b[SHW-1:0]`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; accepted on a rising edge when `busy`=0.
- `alu_ctrl`  in  3  operation code from ALU control.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B; shift amount for shift ops.
- `busy`  out  1  high while an iterative shift is in progress.
- `done`  out  1  one-cycle pulse; `result` and flags valid and updated.
- `result`  out  WIDTH  registered result; held until the next completion.
- `zero`  out  1  registered, equals (`result`==0).
- `ovf`  out  1  registered signed overflow for ADD/SUB; 0 for other ops.

## Operation

- Op codes: 000 ADD a+b; 001 SUB a−b; 010 NOT ~a; 011 SLL a<<n; 100 SRL a>>n (zero fill); 101 AND; 110 OR; 111 SLT: 1 if signed(a)<signed(b), else 0.
- Arithmetic modulo 2^WIDTH; carry-out discarded. `ovf` on ADD: operand signs equal and result sign differs; on SUB: operand signs differ and result sign differs from `a`.
- States: IDLE, SHIFT.
- IDLE, `start`=1: latch `alu_ctrl`, `a`, `b`.
  - Non-shift op, or shift with n=`b[SHW-1:0]`=0: compute; register `result`/`zero`/`ovf`; `done`=1 next cycle; stay IDLE.
  - Shift with n>0: load work register with `a` and counter with n; go SHIFT; `busy`=1.
- SHIFT: each edge shifts the work register one bit in the latched direction and decrements the counter. On the edge where the counter goes 1→0: write `result`, `zero`, `ovf`=0; pulse `done`; return to IDLE; `busy`=0.
- `start` while `busy`=1 is ignored; no queuing. Input changes during SHIFT have no effect.
- `done` is never high in two consecutive cycles for one request. Back-to-back single-cycle ops give `done` high on consecutive cycles, one per request.
- Upper `b` bits above SHW are ignored for shifts.

## Timing

- Reset values (`rst_n`=0, asynchronous): state IDLE, `busy`=0, `done`=0, `result`=0, `zero`=1, `ovf`=0, counter and work register 0.
- Reset mid-SHIFT aborts the operation immediately; no `done` is issued. After release, `result`=0 and `zero`=1.
- Latency: `start` sampled at edge E0. Single-cycle ops and shift-by-0 have `done` high in the cycle after E0. Shift-by-n has `done` high in the cycle after E0+n edges.
- `busy` rises in the cycle after E0 for n>0. It falls in the same cycle `done` rises, so a new `start` may be presented while `done`=1 and is accepted on that edge.
- Throughput: 1 op/cycle for non-shift ops; a shift by n occupies n+1 edges including the accept edge.
- `result`, `zero`, and `ovf` change only on completion edges. At all other times they hold.

## Test plan

- Reset: hold `rst_n`=0 with random inputs → `result`=0, `zero`=1, `ovf`=0, `busy`=0, `done`=0. Assert reset mid-shift → same values at once, and no `done` follows.
- ADD/SUB: ADD 0x7FFF+0x0001 → 0x8000, `ovf`=1, `zero`=0, `done` one cycle later. SUB 0x1234−0x1234 → 0x0000, `zero`=1, `ovf`=0.
- Logic and SLT, back-to-back:
  - NOT 0x00FF → 0xFF00.
  - AND 0xF0F0,0x0FF0 → 0x00F0.
  - OR → 0xFFF0.
  - SLT 0x8000,0x0001 → 0x0001.
  - SLT 0x0001,0x8000 → 0x0000.
  - `start` every cycle → `done` every cycle, results in order.
- Shifts: SLL 0x0001 by 15 → `busy` for 15 cycles, then `done` with 0x8000. SRL 0x8000 by 4 → 0x0800 after 4 cycles. SLL by 0 → `a` unchanged, single-cycle.
- Busy interlock: during a shift by 8, drive `start` with ADD and new operands → ignored; the shift result is unaffected. A `start` presented in the `done` cycle is accepted, with its `done` one cycle later.
- Shift-amount masking: SRL 0xFFFF with `b`=0x0013 → shift by 3 → 0x1FFF.
